// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - instruction-in / immediate-out handshake bundle for imm_decode_stage
interface imm_decode_stage_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [2:0]       out_fmt;
   logic [CNT_W-1:0] illegal_cnt;

   // Upstream/downstream agent view: drives instructions and out_ready
   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, illegal_cnt
   );

   // Decode stage view
   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, illegal_cnt
   );
endinterface

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - RISC-V immediate/format decoder with 2-entry skid FIFO and illegal counter
module imm_decode_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   imm_decode_stage_if.slave     bus
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   logic [31:0]      w_instr;
   logic [2:0]       w_fmt;
   logic [31:0]      w_imm32;
   logic [XLEN-1:0]  w_imm;
   logic             w_accept;
   logic             w_retire;

   logic [XLEN-1:0]  r_imm [0:1];
   logic [2:0]       r_fmt [0:1];
   logic             r_rd_ptr;
   logic             r_wr_ptr;
   logic [1:0]       r_occ;
   logic [CNT_W-1:0] r_cnt;

   assign w_instr = bus.in_instr;

   // Classify the opcode; the RV64 word-op opcodes are only legal when XLEN is 64
   always_comb begin
      w_fmt = FMT_ILL;
      case (w_instr[6:0])
         7'b0000011, 7'b0010011, 7'b1100111,
         7'b0001111, 7'b1110011: w_fmt = FMT_I;
         7'b0100011:             w_fmt = FMT_S;
         7'b1100011:             w_fmt = FMT_B;
         7'b0110111, 7'b0010111: w_fmt = FMT_U;
         7'b1101111:             w_fmt = FMT_J;
         7'b0110011:             w_fmt = FMT_R;
         7'b0011011:             w_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
         7'b0111011:             w_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
         default:                w_fmt = FMT_ILL;
      endcase
   end

   // Assemble the 32-bit immediate for the decoded format; R and illegal give zero
   always_comb begin
      w_imm32 = 32'd0;
      case (w_fmt)
         FMT_I: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
         FMT_S: w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         FMT_B: w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                           w_instr[30:25], w_instr[11:8], 1'b0};
         FMT_U: w_imm32 = {w_instr[31:12], 12'd0};
         FMT_J: w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                           w_instr[20], w_instr[30:21], 1'b0};
         default: w_imm32 = 32'd0;
      endcase
   end

   // Bit 31 of the 32-bit immediate already carries instr[31] for every signed format
   assign w_imm = XLEN'($signed(w_imm32));

   // Ready depends on occupancy alone so there is no combinational path from out_ready
   assign bus.in_ready    = (r_occ != 2'd2);
   assign bus.out_valid   = (r_occ != 2'd0);
   assign bus.out_imm     = r_imm[r_rd_ptr];
   assign bus.out_fmt     = r_fmt[r_rd_ptr];
   assign bus.illegal_cnt = r_cnt;

   assign w_accept = bus.in_valid && bus.in_ready;
   assign w_retire = bus.out_valid && bus.out_ready;

   // FIFO storage and pointers; flush empties without retiring and discards a same-cycle accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_imm[0] <= '0;
         r_imm[1] <= '0;
         r_fmt[0] <= FMT_R;
         r_fmt[1] <= FMT_R;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else if (flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_accept) begin
            r_imm[r_wr_ptr] <= w_imm;
            r_fmt[r_wr_ptr] <= w_fmt;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_retire) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_accept, w_retire})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Saturating count of accepted illegal instructions; flush neither counts nor clears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_accept && !flush && (w_fmt == FMT_ILL) && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed-vector self-checking bench for imm_decode_stage
module tb_imm_decode_stage;

   logic clk;
   logic rst_n;
   logic flush;

   int n_checks;
   int n_fails;

   imm_decode_stage_if #(.XLEN(32), .CNT_W(2))  if32 ();
   imm_decode_stage_if #(.XLEN(64), .CNT_W(16)) if64 ();

   assign if64.in_valid  = if32.in_valid;
   assign if64.in_instr  = if32.in_instr;
   assign if64.out_ready = if32.out_ready;

   imm_decode_stage #(.XLEN(32), .CNT_W(2)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (if32.slave)
   );

   imm_decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (if64.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] vec_instr [0:5];
   logic [31:0] vec_imm   [0:5];
   logic [2:0]  vec_fmt   [0:5];

   initial begin
      n_checks = 0;
      n_fails  = 0;

      vec_instr[0] = 32'hFFC12083; vec_imm[0] = 32'hFFFFFFFC; vec_fmt[0] = 3'd1;
      vec_instr[1] = 32'h00512423; vec_imm[1] = 32'h00000008; vec_fmt[1] = 3'd2;
      vec_instr[2] = 32'hFE000CE3; vec_imm[2] = 32'hFFFFFFF8; vec_fmt[2] = 3'd3;
      vec_instr[3] = 32'h123450B7; vec_imm[3] = 32'h12345000; vec_fmt[3] = 3'd4;
      vec_instr[4] = 32'h001000EF; vec_imm[4] = 32'h00000800; vec_fmt[4] = 3'd5;
      vec_instr[5] = 32'h00000033; vec_imm[5] = 32'h00000000; vec_fmt[5] = 3'd0;

      rst_n          = 1'b0;
      flush          = 1'b0;
      if32.in_valid  = 1'b0;
      if32.in_instr  = 32'd0;
      if32.out_ready = 1'b0;

      // reset values, before any clock edge
      #2;
      check("rst_in_ready",  if32.in_ready,    1);
      check("rst_out_valid", if32.out_valid,   0);
      check("rst_out_imm",   if32.out_imm,     0);
      check("rst_out_fmt",   if32.out_fmt,     0);
      check("rst_cnt",       if32.illegal_cnt, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // format/immediate vectors, streaming with out_ready=1
      if32.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if32.in_valid = 1'b1;
         if32.in_instr = vec_instr[i];
         step();
         check($sformatf("vec%0d_valid", i), if32.out_valid, 1);
         check($sformatf("vec%0d_imm32", i), if32.out_imm, vec_imm[i]);
         check($sformatf("vec%0d_fmt", i),   if32.out_fmt, vec_fmt[i]);
         check($sformatf("vec%0d_imm64", i), if64.out_imm,
               {{32{vec_imm[i][31]}}, vec_imm[i]});
      end
      if32.in_valid = 1'b0;
      step();
      check("drain_valid", if32.out_valid, 0);

      // backpressure: A,B fill the buffer, C held, then ordered drain
      if32.out_ready = 1'b0;
      if32.in_valid  = 1'b1;
      if32.in_instr  = 32'h00100093;
      step();
      check("bp_a_ready", if32.in_ready, 1);
      check("bp_a_imm",   if32.out_imm,  1);
      if32.in_instr = 32'h00200093;
      step();
      check("bp_b_ready", if32.in_ready,  0);
      check("bp_b_valid", if32.out_valid, 1);
      if32.in_instr = 32'h00300093;
      step();
      step();
      check("bp_c_held_ready", if32.in_ready, 0);
      check("bp_head_stable",  if32.out_imm,  1);
      if32.out_ready = 1'b1;
      step();
      check("bp_retire_a_imm",   if32.out_imm,  2);
      check("bp_retire_a_ready", if32.in_ready, 1);
      step();
      check("bp_retire_b_imm",   if32.out_imm,   3);
      check("bp_retire_b_valid", if32.out_valid, 1);
      if32.in_valid = 1'b0;
      step();
      check("bp_retire_c_valid", if32.out_valid, 0);

      // illegal instructions and counter saturation
      if32.in_valid = 1'b1;
      if32.in_instr = 32'h00000000;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("ill%0d_fmt", i),   if32.out_fmt, 7);
         check($sformatf("ill%0d_imm", i),   if32.out_imm, 0);
         check($sformatf("ill%0d_cnt32", i), if32.illegal_cnt, (i < 3) ? i + 1 : 3);
         check($sformatf("ill%0d_cnt64", i), if64.illegal_cnt, i + 1);
      end
      if32.in_instr = 32'h0000001B;
      step();
      check("op1b_fmt32", if32.out_fmt,     7);
      check("op1b_fmt64", if64.out_fmt,     1);
      check("op1b_cnt64", if64.illegal_cnt, 5);
      if32.in_instr = 32'h0000003B;
      step();
      check("op3b_fmt32", if32.out_fmt,     7);
      check("op3b_fmt64", if64.out_fmt,     0);
      check("op3b_cnt64", if64.illegal_cnt, 5);
      if32.in_instr = 32'h00000010;
      step();
      check("lowbits_fmt64", if64.out_fmt,     7);
      check("lowbits_cnt64", if64.illegal_cnt, 6);
      if32.in_valid = 1'b0;
      step();

      // flush at occupancy 2 with in_valid, then flush with a would-be illegal accept
      if32.out_ready = 1'b0;
      if32.in_valid  = 1'b1;
      if32.in_instr  = 32'h00100093;
      step();
      step();
      check("fl_full_ready", if32.in_ready, 0);
      if32.in_instr = 32'h00000000;
      flush = 1'b1;
      step();
      check("fl_valid", if32.out_valid,   0);
      check("fl_ready", if32.in_ready,    1);
      check("fl_cnt64", if64.illegal_cnt, 6);
      step();
      check("fl_accept_valid", if32.out_valid,   0);
      check("fl_accept_cnt64", if64.illegal_cnt, 6);
      flush = 1'b0;

      // asynchronous reset between edges with the buffer full
      if32.in_instr = 32'h00100093;
      step();
      step();
      check("ar_full_ready", if32.in_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", if32.out_valid,   0);
      check("ar_ready", if32.in_ready,    1);
      check("ar_imm",   if32.out_imm,     0);
      check("ar_fmt",   if32.out_fmt,     0);
      check("ar_cnt32", if32.illegal_cnt, 0);
      check("ar_cnt64", if64.illegal_cnt, 0);
      #1;
      rst_n = 1'b1;
      if32.out_ready = 1'b1;
      if32.in_instr  = 32'hFFC12083;
      step();
      check("ar_first_valid", if32.out_valid, 1);
      check("ar_first_imm",   if32.out_imm,   32'hFFFFFFFC);
      if32.in_valid = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: datapath width; legal values 32 and 64.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 The block SHALL have ports in_valid  input  1, in_ready  output  1, in_instr  input  32: upstream instruction handshake.
REQ-007 The block SHALL have ports out_valid  output  1, out_ready  input  1: downstream handshake.
REQ-008 The block SHALL have port out_imm  output  XLEN  decoded, sign-extended immediate.
REQ-009 The block SHALL have port out_fmt  output  3  format: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
REQ-010 The block SHALL have port illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-011 Format SHALL be decoded from in_instr[6:0]: I = 0000011, 0010011, 1100111, 0001111, 1110011; S = 0100011; B = 1100011; U = 0110111, 0010111; J = 1101111; R = 0110011.
REQ-012 When XLEN=64, 0011011 SHALL decode as I and 0111011 as R; when XLEN=32 both SHALL be illegal.
REQ-013 Any other opcode, including in_instr[1:0] != 2'b11, SHALL be illegal: out_fmt=7, out_imm=0.
REQ-014 I imm SHALL be sext(instr[31:20]); S imm SHALL be sext({instr[31:25],instr[11:5]... instr[11:7]}) i.e. sext({instr[31:25],instr[11:7]}).
REQ-015 B imm SHALL be sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}) (LSB forced zero).
REQ-016 U imm SHALL be sext({instr[31:12],12'b0}); J imm SHALL be sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
REQ-017 R format SHALL produce out_imm=0; all sign extension SHALL replicate instr[31] to bit XLEN-1.
REQ-018 Decode SHALL occur at input; decoded {imm,fmt} SHALL be stored in a 2-entry FIFO skid buffer.
REQ-019 A transfer SHALL occur on in_valid&&in_ready (accept) and out_valid&&out_ready (retire).
REQ-020 Latency SHALL be exactly 1 cycle: an instruction accepted at edge N into an empty buffer SHALL appear on out_* after edge N.
REQ-021 in_ready SHALL be driven from occupancy state only (in_ready = occupancy<2); no combinational path from out_ready or in_valid.
REQ-022 out_valid SHALL equal occupancy>0; out_imm/out_fmt SHALL show the oldest entry and SHALL be stable while out_valid&&!out_ready.
REQ-023 Order SHALL be preserved; simultaneous accept and retire at occupancy 1 SHALL keep occupancy 1 with the new entry at head next cycle.
REQ-024 At occupancy 2 in_ready=0; no accept; a retire SHALL reduce occupancy to 1 and raise in_ready next cycle.
REQ-025 flush=1 SHALL empty the buffer at the next edge, discard any same-cycle accept, and not retire; out_valid=0, in_ready=1 next cycle.
REQ-026 illegal_cnt SHALL increment by 1 on each accept of an illegal instruction when flush=0, saturating at all ones.
REQ-027 flush SHALL NOT clear illegal_cnt; handshake signals SHALL tolerate X-free idle inputs with in_valid=0.

Reset
REQ-028 While rst_n=0, regardless of clk: occupancy=0, out_valid=0, in_ready=1, out_imm=0, out_fmt=0, illegal_cnt=0.
REQ-029 rst_n assertion mid-transfer SHALL drop all buffered entries immediately; first accept possible on first edge after release.

Verification
REQ-030 out_ready=1, XLEN=32: in_instr 0xFFC12083 -> next cycle out_imm 0xFFFFFFFC, out_fmt 1; 0x00512423 -> 0x00000008, fmt 2.
REQ-031 0xFE000CE3 -> out_imm 0xFFFFFFF8, fmt 3; 0x123450B7 -> 0x12345000, fmt 4; 0x001000EF -> 0x00000800, fmt 5; XLEN=64 run of 0xFE000CE3 -> 0xFFFFFFFFFFFFFFF8.
REQ-032 out_ready=0, push A,B,C back-to-back -> A,B accepted, in_ready=0 from cycle after B, C held; out_ready=1 -> A,B,C retire in order, one per cycle.
REQ-033 CNT_W=2, accept 0x00000000 five times -> out_fmt 7, out_imm 0 each; illegal_cnt 1,2,3,3,3; XLEN=32 accept 0x0000001B -> fmt 7.
REQ-034 Occupancy 2 plus in_valid, assert flush -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged; repeat with rst_n pulsed low between edges -> all outputs at reset values immediately.
